tile_lookup_arb: RTL

//   Shares the single read port of the 48x27 tile-map RAM among N_REQ movers
//   (enemies 0..3, player). Each mover supplies a probe pixel (x,y) and gets

---
 rtl/tile_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 45 ++++
 rtl/tile_lookup_arb.sv | 109 ++++++++++
 3 files changed

// File: rtl/tile_pkg.sv
// Shared tile-map geometry and tile code constants for the mover/tile-map path.
package tile_pkg;
  localparam int MAP_W   = 48;
  localparam int MAP_H   = 27;
  localparam int TILE_PX = 40;
  localparam int SCR_W   = 1920;
  localparam int SCR_H   = 1080;

  localparam int ADDR_W  = 11;
  localparam int CODE_W  = 4;
  localparam int COORD_W = 12;

  localparam logic [CODE_W-1:0] TILE_BG   = 4'd0;
  localparam logic [CODE_W-1:0] TILE_WALL = 4'd1;
  localparam logic [CODE_W-1:0] TILE_COIN = 4'd2;
endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: one-hot grant, search starts at ptr, ptr moves past the winner.
module rr_arbiter #(
  parameter int N  = 5,
  parameter int IW = 3
) (
  input  logic          clk_pix,
  input  logic          rstn,
  input  logic          clear,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_any
);
  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;
  logic          block;

  // rstn gates the grant combinationally so req_ready is 0 the moment reset asserts
  assign block = clear | ~rstn;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!block && !grant_any && req[cand]) begin
        grant_any   = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_pix or negedge rstn) begin
    if (!rstn) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (grant_any) begin
      ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
endmodule

// File: rtl/tile_lookup_arb.sv
// Shares the tile-map RAM read port among the movers: round-robin grant, pixel-to-tile
// address, fixed-latency tagged pipeline back to each requester.
module tile_lookup_arb
  import tile_pkg::*;
#(
  parameter int N_REQ = 5,
  parameter int RD_LAT = 1,
  parameter int ADDR_W = tile_pkg::ADDR_W,
  parameter int CODE_W = tile_pkg::CODE_W
) (
  input  logic                       clk_pix,
  input  logic                       rstn,
  input  logic                       clear,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [12*N_REQ-1:0]        req_x,
  input  logic [12*N_REQ-1:0]        req_y,
  output logic [N_REQ-1:0]           req_ready,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic [ADDR_W*N_REQ-1:0]    rsp_addr,
  output logic [CODE_W*N_REQ-1:0]    rsp_code,
  output logic                       mem_en,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic [CODE_W-1:0]          mem_code
);
  // Handshake: a requester holds req_valid with stable x,y; the transfer is the cycle where
  // req_valid[i] & req_ready[i]. Responses are never stalled, so there is no rsp ready.
  localparam int TW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] grant;
  logic [TW-1:0]    gidx;
  logic             gany;

  rr_arbiter #(.N(N_REQ), .IW(TW)) u_arb (
    .clk_pix   (clk_pix),
    .rstn      (rstn),
    .clear     (clear),
    .req       (req_valid),
    .grant     (grant),
    .grant_idx (gidx),
    .grant_any (gany)
  );

  assign req_ready = grant;

  logic [11:0]       sel_x, sel_y, col, row;
  logic [17:0]       lin;
  logic [ADDR_W-1:0] addr;
  logic              oob;

  always_comb begin
    sel_x = req_x[12*gidx +: 12];
    sel_y = req_y[12*gidx +: 12];
    col   = sel_x / 12'(TILE_PX);
    row   = sel_y / 12'(TILE_PX);
    lin   = 18'(row) * 18'(MAP_W) + 18'(col);
    addr  = lin[ADDR_W-1:0];
    oob   = (col >= 12'(MAP_W)) || (row >= 12'(MAP_H));
  end

  // Stage s holds the entry accepted s+1 cycles ago; the last stage meets mem_code.
  logic [RD_LAT:0]             p_valid;
  logic [RD_LAT:0][TW-1:0]     p_tag;
  logic [RD_LAT:0][ADDR_W-1:0] p_addr;
  logic [RD_LAT:0]             p_oob;
  logic                        mem_en_q;

  assign mem_en = mem_en_q & ~clear;

  always_ff @(posedge clk_pix or negedge rstn) begin
    if (!rstn) begin
      p_valid   <= '0;
      p_tag     <= '0;
      p_addr    <= '0;
      p_oob     <= '0;
      mem_en_q  <= 1'b0;
      mem_addr  <= '0;
      rsp_valid <= '0;
      rsp_addr  <= '0;
      rsp_code  <= '0;
    end else begin
      p_valid[0] <= gany & ~clear;
      p_tag[0]   <= gidx;
      p_addr[0]  <= addr;
      p_oob[0]   <= oob;
      for (int s = 1; s <= RD_LAT; s++) begin
        p_valid[s] <= p_valid[s-1] & ~clear;
        p_tag[s]   <= p_tag[s-1];
        p_addr[s]  <= p_addr[s-1];
        p_oob[s]   <= p_oob[s-1];
      end

      mem_en_q <= gany & ~oob;
      if (gany) begin
        mem_addr <= oob ? '0 : addr;
      end

      rsp_valid <= '0;
      if (p_valid[RD_LAT] && !clear) begin
        for (int i = 0; i < N_REQ; i++) begin
          if (p_tag[RD_LAT] == TW'(i)) begin
            rsp_valid[i]                  <= 1'b1;
            rsp_addr[i*ADDR_W +: ADDR_W] <= p_addr[RD_LAT];
            rsp_code[i*CODE_W +: CODE_W] <= p_oob[RD_LAT] ? TILE_WALL : mem_code;
          end
        end
      end
    end
  end
endmodule
